// File: rtl/gbe_udp_rx_checker_pkg.sv
// Shared definitions for the gbe_udp RX pattern checker.
//   PATTERN_WORD_W : width of one pattern word (big-endian 16-bit index)
//   chk_state_e    : FSM states; each names the kind of byte consumed last
package gbe_udp_rx_checker_pkg;

    localparam int unsigned PATTERN_WORD_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSeedHi,
        StSeedLo,
        StHi,
        StLo,
        StDrain
    } chk_state_e;

endpackage

// File: rtl/gbe_udp_rx_checker_if.sv
// Application RX port of gbe_udp.
//   master : gbe_udp side, drives payload bytes and status, receives ack/rst
//   slave  : consumer side (the checker)
//   app_rx_data/dvld/eof    payload byte stream
//   app_rx_srcip/srcport    frame source, valid with dvld
//   app_rx_badframe         frame bad, qualified by dvld & eof
//   app_rx_overrun          RX buffer overrun
//   app_rx_ack              consume current byte
//   app_rx_rst              RX buffer reset request
interface gbe_udp_rx_checker_if;
    logic [7:0]  app_rx_data;
    logic        app_rx_dvld;
    logic        app_rx_eof;
    logic [31:0] app_rx_srcip;
    logic [15:0] app_rx_srcport;
    logic        app_rx_badframe;
    logic        app_rx_overrun;
    logic        app_rx_ack;
    logic        app_rx_rst;

    modport master (
        output app_rx_data, app_rx_dvld, app_rx_eof, app_rx_srcip, app_rx_srcport,
               app_rx_badframe, app_rx_overrun,
        input  app_rx_ack, app_rx_rst
    );

    modport slave (
        input  app_rx_data, app_rx_dvld, app_rx_eof, app_rx_srcip, app_rx_srcport,
               app_rx_badframe, app_rx_overrun,
        output app_rx_ack, app_rx_rst
    );
endinterface

// File: rtl/gbe_udp_rx_chk_cnt.sv
// Wrapping statistics counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear
//   inc      : add one this cycle
//   cnt      : current count
module gbe_udp_rx_chk_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/gbe_udp_rx_checker.sv
// Drains the gbe_udp application RX port and checks the counting pattern of the
// app TX generator (16-bit word index, high byte first, FRAME_BYTES per frame).
// Optional feature macro: GBE_RX_CHK_CAPTURE_EN (first-error capture, srcport check).
//   app_clk, app_rst : clock, synchronous active-high reset
//   rx               : application RX port (slave side)
//   clr              : synchronous clear of counters and history
//   frame/good/bad/err/lost/ovr_cnt : statistics counters
//   last_word        : final word of the most recent good frame
//   cap_*            : first-error snapshot (capture build only)
module gbe_udp_rx_checker
    import gbe_udp_rx_checker_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 256,
    parameter logic [15:0] EXP_SRCPORT = 16'hbeef,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                      app_clk,
    input  logic                      app_rst,
    gbe_udp_rx_checker_if.slave       rx,
    input  logic                      clr,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic [CNT_W-1:0]          good_cnt,
    output logic [CNT_W-1:0]          bad_cnt,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [CNT_W-1:0]          lost_cnt,
    output logic [CNT_W-1:0]          ovr_cnt,
`ifdef GBE_RX_CHK_CAPTURE_EN
    output logic                      cap_valid,
    output logic [CNT_W-1:0]          cap_frame,
    output logic [15:0]               cap_offset,
    output logic [7:0]                cap_exp,
    output logic [7:0]                cap_got,
`endif
    output logic [PATTERN_WORD_W-1:0] last_word
);

    chk_state_e                state_q, state_d;
    logic                      err_q, err_d;
    logic [7:0]                hi_q, hi_d;
    logic [PATTERN_WORD_W-1:0] word_q, word_d, exp_word, prev_last_q;
    logic [15:0]               byte_cnt_q, byte_cnt_d;
    logic                      hist_q, rx_rst_q, rst_seen_q, ovr_q;
    logic [7:0]                exp_byte;
    logic                      fire, take, ovr_evt, byte_err, len_err, lost_inc;
    logic                      eof_take, bad_inc, err_inc, good_inc;

    assign fire          = rx.app_rx_dvld & ~app_rst & ~rx_rst_q;
    assign rx.app_rx_ack = fire;
    assign rx.app_rx_rst = rx_rst_q;
    // A held overrun level is one event; it also discards the byte of that cycle.
    assign ovr_evt       = rx.app_rx_overrun & ~ovr_q;
    assign take          = fire & ~ovr_evt;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        hi_d       = hi_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        exp_word   = word_q + 16'd1;
        exp_byte   = 8'h00;
        byte_err   = 1'b0;
        len_err    = 1'b0;
        lost_inc   = 1'b0;
        if (ovr_evt) begin
            state_d    = StIdle;
            err_d      = 1'b0;
            byte_cnt_d = '0;
        end else if (take) begin
            // Saturate so an overlong frame can never alias back to a legal length.
            if (byte_cnt_q != 16'(FRAME_BYTES)) byte_cnt_d = byte_cnt_q + 16'd1;
            case (state_q)
                StIdle: begin
                    hi_d    = rx.app_rx_data;
                    state_d = StSeedHi;
`ifdef GBE_RX_CHK_CAPTURE_EN
                    if (rx.app_rx_srcport != EXP_SRCPORT) byte_err = 1'b1;
`endif
                end
                StSeedHi: begin
                    word_d   = {hi_q, rx.app_rx_data};
                    state_d  = StSeedLo;
                    lost_inc = hist_q & ({hi_q, rx.app_rx_data} != prev_last_q + 16'd1);
                end
                StSeedLo, StLo: begin
                    exp_byte = exp_word[15:8];
                    if (rx.app_rx_data != exp_byte) byte_err = 1'b1;
                    else state_d = StHi;
                end
                StHi: begin
                    exp_byte = exp_word[7:0];
                    if (rx.app_rx_data != exp_byte) begin
                        byte_err = 1'b1;
                    end else begin
                        word_d  = exp_word;
                        state_d = StLo;
                    end
                end
                StDrain: state_d = StDrain;
                default: state_d = StIdle;
            endcase
            if (byte_err) begin
                err_d   = 1'b1;
                state_d = StDrain;
            end
            if (rx.app_rx_eof) begin
                len_err    = (byte_cnt_q != 16'(FRAME_BYTES - 1));
                state_d    = StIdle;
                err_d      = 1'b0;
                byte_cnt_d = '0;
            end
        end
    end

    assign eof_take = take & rx.app_rx_eof & ~clr;
    assign bad_inc  = eof_take & rx.app_rx_badframe;
    assign err_inc  = eof_take & ~rx.app_rx_badframe & (err_q | byte_err | len_err);
    assign good_inc = eof_take & ~rx.app_rx_badframe & ~(err_q | byte_err | len_err);

    always_ff @(posedge app_clk) begin
        if (app_rst || clr) state_q <= StIdle;
        else                state_q <= state_d;
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            err_q       <= 1'b0;
            hi_q        <= '0;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            hist_q      <= 1'b0;
            prev_last_q <= '0;
            rx_rst_q    <= 1'b0;
            rst_seen_q  <= 1'b1;
            ovr_q       <= 1'b0;
        end else begin
            ovr_q      <= rx.app_rx_overrun;
            rst_seen_q <= 1'b0;
            if (clr) begin
                err_q       <= 1'b0;
                hi_q        <= '0;
                word_q      <= '0;
                byte_cnt_q  <= '0;
                hist_q      <= 1'b0;
                prev_last_q <= '0;
                rx_rst_q    <= 1'b0;
            end else begin
                err_q      <= err_d;
                hi_q       <= hi_d;
                word_q     <= word_d;
                byte_cnt_q <= byte_cnt_d;
                // One-cycle buffer reset after reset release and after each overrun.
                rx_rst_q   <= rst_seen_q | ovr_evt;
                if (ovr_evt || err_inc) begin
                    hist_q <= 1'b0;
                end else if (good_inc) begin
                    hist_q      <= 1'b1;
                    prev_last_q <= word_d;
                end
            end
        end
    end

    assign last_word = prev_last_q;

    gbe_udp_rx_chk_cnt #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk(app_clk), .rst(app_rst), .clr(clr), .inc(eof_take), .cnt(frame_cnt)
    );
    gbe_udp_rx_chk_cnt #(.CNT_W(CNT_W)) u_good_cnt (
        .clk(app_clk), .rst(app_rst), .clr(clr), .inc(good_inc), .cnt(good_cnt)
    );
    gbe_udp_rx_chk_cnt #(.CNT_W(CNT_W)) u_bad_cnt (
        .clk(app_clk), .rst(app_rst), .clr(clr), .inc(bad_inc), .cnt(bad_cnt)
    );
    gbe_udp_rx_chk_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(app_clk), .rst(app_rst), .clr(clr), .inc(err_inc), .cnt(err_cnt)
    );
    gbe_udp_rx_chk_cnt #(.CNT_W(CNT_W)) u_lost_cnt (
        .clk(app_clk), .rst(app_rst), .clr(clr), .inc(lost_inc & ~clr), .cnt(lost_cnt)
    );
    gbe_udp_rx_chk_cnt #(.CNT_W(CNT_W)) u_ovr_cnt (
        .clk(app_clk), .rst(app_rst), .clr(clr), .inc(ovr_evt & ~clr), .cnt(ovr_cnt)
    );

`ifdef GBE_RX_CHK_CAPTURE_EN
    logic unused_src;
    assign unused_src = ^rx.app_rx_srcip;

    always_ff @(posedge app_clk) begin
        if (app_rst || clr) begin
            cap_valid  <= 1'b0;
            cap_frame  <= '0;
            cap_offset <= '0;
            cap_exp    <= '0;
            cap_got    <= '0;
        end else if (take && (byte_err || len_err) && !cap_valid) begin
            cap_valid  <= 1'b1;
            cap_frame  <= frame_cnt;
            cap_offset <= byte_cnt_q;
            cap_exp    <= exp_byte;
            cap_got    <= rx.app_rx_data;
        end
    end
`else
    logic unused_src;
    assign unused_src = ^{rx.app_rx_srcip, rx.app_rx_srcport, EXP_SRCPORT};
`endif

endmodule

// File: tb/tb_gbe_udp_rx_checker.sv
// Self-checking bench for gbe_udp_rx_checker: directed scenarios plus randomized
// frames, checked against a frame-level reference model.
module tb_gbe_udp_rx_checker;

    localparam int unsigned FB = 256;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic [CW-1:0] frame_cnt, good_cnt, bad_cnt, err_cnt, lost_cnt, ovr_cnt;
    logic [15:0]   last_word;

    gbe_udp_rx_checker_if rx_if ();

    gbe_udp_rx_checker #(
        .FRAME_BYTES(FB),
        .EXP_SRCPORT(16'hbeef),
        .CNT_W      (CW)
    ) dut (
        .app_clk  (clk),
        .app_rst  (rst),
        .rx       (rx_if),
        .clr      (clr),
        .frame_cnt(frame_cnt),
        .good_cnt (good_cnt),
        .bad_cnt  (bad_cnt),
        .err_cnt  (err_cnt),
        .lost_cnt (lost_cnt),
        .ovr_cnt  (ovr_cnt),
        .last_word(last_word)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned m_frame, m_good, m_bad, m_err, m_lost, m_ovr;
    logic [15:0] m_last;
    bit          m_hist;
    logic [7:0]  fq[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_frame = 0; m_good = 0; m_bad = 0; m_err = 0; m_lost = 0; m_ovr = 0;
        m_last  = 16'h0;
        m_hist  = 1'b0;
    endtask

    task automatic model_frame(input bit bf);
        int          n;
        bit          ok;
        logic [15:0] seed;
        n    = fq.size();
        ok   = (n == FB);
        seed = 16'h0;
        if (n >= 2) begin
            seed = {fq[0], fq[1]};
            if (m_hist && seed != m_last + 16'd1) m_lost++;
        end
        for (int i = 0; i + 1 < n; i += 2)
            if ({fq[i], fq[i+1]} != seed + 16'(i / 2)) ok = 1'b0;
        m_frame++;
        if (bf) begin
            m_bad++;
        end else if (!ok) begin
            m_err++;
            m_hist = 1'b0;
        end else begin
            m_good++;
            m_last = seed + 16'(n / 2 - 1);
            m_hist = 1'b1;
        end
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, ".frame"}, frame_cnt, m_frame);
        check_eq({tag, ".good"},  good_cnt,  m_good);
        check_eq({tag, ".bad"},   bad_cnt,   m_bad);
        check_eq({tag, ".err"},   err_cnt,   m_err);
        check_eq({tag, ".lost"},  lost_cnt,  m_lost);
        check_eq({tag, ".ovr"},   ovr_cnt,   m_ovr);
        check_eq({tag, ".last"},  last_word, m_last);
    endtask

    task automatic build_frame(input logic [15:0] seed, input int n);
        logic [15:0] w;
        fq.delete();
        for (int i = 0; i < n; i++) begin
            w = seed + 16'(i / 2);
            fq.push_back((i % 2 == 0) ? w[15:8] : w[7:0]);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rx_if.app_rx_dvld     = 1'b0;
        rx_if.app_rx_eof      = 1'b0;
        rx_if.app_rx_badframe = 1'b0;
        #1;
        check_eq("ack_idle", rx_if.app_rx_ack, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit e, input bit bf);
        @(negedge clk);
        rx_if.app_rx_data     = b;
        rx_if.app_rx_dvld     = 1'b1;
        rx_if.app_rx_eof      = e;
        rx_if.app_rx_badframe = bf;
        #1;
        check_eq("ack", rx_if.app_rx_ack, 1'b1);
    endtask

    // badframe is randomized on non-eof bytes; only the eof byte's value matters.
    task automatic send_frame(input bit bf, input string tag);
        int n;
        n = fq.size();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            send_byte(fq[i], i == n - 1, (i == n - 1) ? bf : 1'($urandom_range(0, 1)));
        end
        model_frame(bf);
        idle_cycle();
        check_counters(tag);
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        rx_if.app_rx_data     = 8'h00;
        rx_if.app_rx_dvld     = 1'b0;
        rx_if.app_rx_eof      = 1'b0;
        rx_if.app_rx_srcip    = 32'h0a000001;
        rx_if.app_rx_srcport  = 16'hbeef;
        rx_if.app_rx_badframe = 1'b0;
        rx_if.app_rx_overrun  = 1'b0;
        model_clear();

        // Reset: no ack while in reset, then a single app_rx_rst pulse after release.
        repeat (4) @(negedge clk);
        rx_if.app_rx_dvld = 1'b1;
        #1;
        check_eq("ack_in_reset", rx_if.app_rx_ack, 1'b0);
        check_eq("rxrst_in_reset", rx_if.app_rx_rst, 1'b0);
        check_counters("reset");
        @(negedge clk);
        rst = 1'b0;
        rx_if.app_rx_dvld = 1'b0;
        @(negedge clk);
        rx_if.app_rx_dvld = 1'b1;
        #1;
        check_eq("rxrst_after_reset", rx_if.app_rx_rst, 1'b1);
        check_eq("ack_during_rxrst", rx_if.app_rx_ack, 1'b0);
        idle_cycle();
        check_eq("rxrst_one_cycle", rx_if.app_rx_rst, 1'b0);

        // Back-to-back good frames, then a discontinuity.
        build_frame(16'd0, FB);   send_frame(1'b0, "words0_127");
        build_frame(16'd128, FB); send_frame(1'b0, "words128_255");
        check_eq("last_word_255", last_word, 16'd255);
        build_frame(16'd300, FB); send_frame(1'b0, "jump300");
        check_eq("lost_is_1", lost_cnt, 1);

        // Corrupted byte, then a good frame.
        build_frame(m_last + 16'd1, FB);
        fq[50] = fq[50] ^ 8'h80;
        send_frame(1'b0, "corrupt50");
        build_frame(16'd1000, FB); send_frame(1'b0, "after_corrupt");

        // Length errors and badframe.
        build_frame(m_last + 16'd1, 200); send_frame(1'b0, "short200");
        build_frame(m_last + 16'd1, FB);  send_frame(1'b1, "badframe");
        build_frame(16'd7, 1);            send_frame(1'b0, "len1");
        build_frame(m_last + 16'd1, FB + 2); send_frame(1'b0, "long258");

        // Overrun mid-frame.
        build_frame(16'd50, FB);
        for (int i = 0; i < 100; i++) send_byte(fq[i], 1'b0, 1'b0);
        @(negedge clk);
        rx_if.app_rx_dvld    = 1'b0;
        rx_if.app_rx_overrun = 1'b1;
        @(negedge clk);
        rx_if.app_rx_overrun = 1'b0;
        rx_if.app_rx_dvld    = 1'b1;
        #1;
        check_eq("ovr_rxrst", rx_if.app_rx_rst, 1'b1);
        check_eq("ovr_ack_blocked", rx_if.app_rx_ack, 1'b0);
        m_ovr++;
        m_hist = 1'b0;
        idle_cycle();
        check_eq("ovr_rxrst_one_cycle", rx_if.app_rx_rst, 1'b0);
        check_counters("overrun");
        build_frame(16'd9000, FB); send_frame(1'b0, "after_ovr");

        // clr coinciding with eof: frame not counted, everything cleared.
        build_frame(m_last + 16'd1, FB);
        for (int i = 0; i < FB - 1; i++) send_byte(fq[i], 1'b0, 1'b0);
        @(negedge clk);
        rx_if.app_rx_data = fq[FB-1];
        rx_if.app_rx_dvld = 1'b1;
        rx_if.app_rx_eof  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rx_if.app_rx_dvld = 1'b0;
        rx_if.app_rx_eof  = 1'b0;
        model_clear();
        #1;
        check_counters("clr_eof");

        // Wrapping pattern after clear.
        build_frame(16'hffc0, FB); send_frame(1'b0, "wrap");
        check_eq("wrap_last", last_word, 16'h003f);

        // Randomized frames.
        for (int k = 0; k < 30; k++) begin
            int unsigned kind;
            bit          bf;
            kind = $urandom_range(0, 5);
            bf   = 1'b0;
            case (kind)
                0, 1: build_frame(m_hist ? m_last + 16'd1 : 16'($urandom), FB);
                2:    build_frame(16'($urandom), FB);
                3: begin
                    int idx;
                    build_frame(m_last + 16'd1, FB);
                    idx = $urandom_range(0, FB - 1);
                    fq[idx] = fq[idx] ^ (8'h01 << $urandom_range(0, 7));
                end
                4:    build_frame(m_last + 16'd1, $urandom_range(1, FB + 4));
                default: begin
                    build_frame(m_last + 16'd1, FB);
                    bf = 1'b1;
                end
            endcase
            send_frame(bf, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
